kvs_mc_parser: RTL

// - Memcached binary-protocol request parser for the KVS RX path; one clock domain (rx_clk).
// - Input is the UDP payload byte stream produced by the RX header filter
//   (mc_dv/mc_data = memcache_dv/rxd). mc_dv rises on the first byte of the 24-byte binary header.
// - Outputs:
//   - decoded header fields
//   - key byte stream plus a 17-bit key hash that feeds the mem_address port of the storage RAM
//   - value byte stream for SET
//   - done/error pulses for the TX response builder

---
 rtl/kvs_pkg.sv | 28 ++
 rtl/kvs_key_hash.sv | 35 +++
 rtl/kvs_mc_parser.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kvs_pkg.sv
// Shared constants and FSM encoding for the memcached binary-protocol datapath.
// Used by the RX parser and the TX response builder.
package kvs_pkg;

   localparam logic [7:0] MC_MAGIC_REQ = 8'h80;
   localparam logic [7:0] MC_MAGIC_RSP = 8'h81;
   localparam logic [7:0] MC_OP_GET    = 8'h00;
   localparam logic [7:0] MC_OP_SET    = 8'h01;
   localparam int         MC_HDR_LEN   = 24;
   localparam logic [4:0] MC_HDR_LAST  = 5'(MC_HDR_LEN - 1);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_MAGIC   = 3'd1;
   localparam logic [2:0] ERR_TRUNC   = 3'd2;
   localparam logic [2:0] ERR_KEY_LEN = 3'd3;
   localparam logic [2:0] ERR_LEN     = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_EXT   = 3'd2,
      ST_KEY   = 3'd3,
      ST_VAL   = 3'd4,
      ST_DONE  = 3'd5,
      ST_DRAIN = 3'd6
   } mc_state_e;

endpackage

// File: rtl/kvs_key_hash.sv
// Rotate-left-5 / XOR key hash; the result addresses the storage RAM directly.
// Shared between the RX parser and the TX path.
module kvs_key_hash #(
   parameter int HASH_W = 17
) (
   input  logic              rx_clk,
   input  logic              sys_rst,
   input  logic              clr,
   input  logic              en,
   input  logic [7:0]        data,
   output logic [HASH_W-1:0] hash
);

   logic [HASH_W-1:0] hash_r;

   function automatic logic [HASH_W-1:0] hash_step(input logic [HASH_W-1:0] h, input logic [7:0] b);
      hash_step = {h[HASH_W-6:0], h[HASH_W-1:HASH_W-5]} ^ {{(HASH_W-8){1'b0}}, b};
   endfunction

   // Hash accumulator; clear wins over a simultaneous update
   always_ff @(posedge rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hash_r <= '0;
      end else if (clr) begin
         hash_r <= '0;
      end else if (en) begin
         hash_r <= hash_step(hash_r, data);
      end else begin
         hash_r <= hash_r;
      end
   end

   assign hash = hash_r;

endmodule

// File: rtl/kvs_mc_parser.sv
// Memcached binary request parser: header decode, key stream + hash, value stream,
// done/error pulses toward the TX response builder. All outputs registered.
module kvs_mc_parser
   import kvs_pkg::*;
#(
   parameter int MAX_KEY = 250,
   parameter int HASH_W  = 17
) (
   input  logic              rx_clk,
   input  logic              sys_rst,
   input  logic              mc_dv,
   input  logic [7:0]        mc_data,
   output logic              hdr_valid,
   output logic [7:0]        hdr_magic,
   output logic [7:0]        hdr_opcode,
   output logic [15:0]       hdr_key_len,
   output logic [7:0]        hdr_ext_len,
   output logic [31:0]       hdr_body_len,
   output logic [31:0]       hdr_opaque,
   output logic              key_dv,
   output logic [7:0]        key_data,
   output logic [HASH_W-1:0] key_hash,
   output logic              key_hash_vld,
   output logic              val_dv,
   output logic [7:0]        val_data,
   output logic              req_done,
   output logic              err_vld,
   output logic [2:0]        err_code
);

   localparam logic [15:0] MAX_KEY_LEN = 16'(MAX_KEY);

   mc_state_e   state_r, state_nx;
   logic [4:0]  idx_r, idx_nx;
   logic [31:0] len_r, len_nx;
   logic        armed_r;
   logic        hdr_cap_s, hash_clr_s, hash_en_s;
   logic        hdr_valid_r, hdr_valid_nx, key_dv_r, key_dv_nx, key_hash_vld_r, key_hash_vld_nx;
   logic        val_dv_r, val_dv_nx, req_done_r, req_done_nx, err_vld_r, err_vld_nx;
   logic [2:0]  err_code_r, err_code_nx;
   logic [7:0]  key_data_r, val_data_r;
   logic [7:0]  hdr_magic_r, hdr_opcode_r, hdr_ext_len_r;
   logic [15:0] hdr_key_len_r;
   logic [31:0] hdr_body_len_r, hdr_opaque_r;
   logic [31:0] val_len_s, after_key_len_s, after_ext_len_s, after_hdr_len_s;
   mc_state_e   after_key_st_s, after_ext_st_s, after_hdr_st_s;
   logic        key_too_long_s, len_bad_s;

   assign val_len_s      = hdr_body_len_r - {24'd0, hdr_ext_len_r} - {16'd0, hdr_key_len_r};
   assign key_too_long_s = (hdr_key_len_r > MAX_KEY_LEN);
   assign len_bad_s      = (({25'd0, hdr_ext_len_r} + {17'd0, hdr_key_len_r}) > {1'b0, hdr_body_len_r});

   // Successor phase after each section, skipping empty sections in the same cycle
   always_comb begin
      after_key_st_s  = ST_DONE;
      after_key_len_s = 32'd0;
      if (val_len_s != 32'd0) begin
         after_key_st_s  = ST_VAL;
         after_key_len_s = val_len_s;
      end else begin
         after_key_st_s  = ST_DONE;
         after_key_len_s = 32'd0;
      end
      if (hdr_key_len_r != 16'd0) begin
         after_ext_st_s  = ST_KEY;
         after_ext_len_s = {16'd0, hdr_key_len_r};
      end else begin
         after_ext_st_s  = after_key_st_s;
         after_ext_len_s = after_key_len_s;
      end
      if (hdr_ext_len_r != 8'd0) begin
         after_hdr_st_s  = ST_EXT;
         after_hdr_len_s = {24'd0, hdr_ext_len_r};
      end else begin
         after_hdr_st_s  = after_ext_st_s;
         after_hdr_len_s = after_ext_len_s;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_nx        = state_r;
      idx_nx          = idx_r;
      len_nx          = len_r;
      hdr_cap_s       = 1'b0;
      hash_clr_s      = 1'b0;
      hash_en_s       = 1'b0;
      hdr_valid_nx    = 1'b0;
      key_dv_nx       = 1'b0;
      key_hash_vld_nx = 1'b0;
      val_dv_nx       = 1'b0;
      req_done_nx     = 1'b0;
      err_vld_nx      = 1'b0;
      err_code_nx     = err_code_r;
      case (state_r)
         ST_IDLE: begin
            // armed_r holds off a frame already in flight when reset released
            if (mc_dv && armed_r) begin
               hdr_cap_s  = 1'b1;
               hash_clr_s = 1'b1;
               if (mc_data == MC_MAGIC_REQ) begin
                  state_nx = ST_HDR;
                  idx_nx   = 5'd1;
               end else begin
                  err_vld_nx  = 1'b1;
                  err_code_nx = ERR_MAGIC;
                  state_nx    = ST_DRAIN;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (!mc_dv) begin
               err_vld_nx  = 1'b1;
               err_code_nx = ERR_TRUNC;
               idx_nx      = 5'd0;
               state_nx    = ST_IDLE;
            end else if (idx_r == MC_HDR_LAST) begin
               hdr_cap_s    = 1'b1;
               hdr_valid_nx = 1'b1;
               idx_nx       = 5'd0;
               if (key_too_long_s) begin
                  err_vld_nx  = 1'b1;
                  err_code_nx = ERR_KEY_LEN;
                  state_nx    = ST_DRAIN;
               end else if (len_bad_s) begin
                  err_vld_nx  = 1'b1;
                  err_code_nx = ERR_LEN;
                  state_nx    = ST_DRAIN;
               end else begin
                  state_nx = after_hdr_st_s;
                  len_nx   = after_hdr_len_s;
               end
            end else begin
               hdr_cap_s = 1'b1;
               idx_nx    = idx_r + 5'd1;
            end
         end
         ST_EXT, ST_KEY, ST_VAL: begin
            if (!mc_dv) begin
               err_vld_nx  = 1'b1;
               err_code_nx = ERR_TRUNC;
               state_nx    = ST_IDLE;
            end else begin
               key_dv_nx = (state_r == ST_KEY);
               hash_en_s = (state_r == ST_KEY);
               val_dv_nx = (state_r == ST_VAL);
               if (len_r == 32'd1) begin
                  if (state_r == ST_EXT) begin
                     state_nx = after_ext_st_s;
                     len_nx   = after_ext_len_s;
                  end else if (state_r == ST_KEY) begin
                     key_hash_vld_nx = 1'b1;
                     state_nx        = after_key_st_s;
                     len_nx          = after_key_len_s;
                  end else begin
                     state_nx = ST_DONE;
                     len_nx   = 32'd0;
                  end
               end else begin
                  len_nx = len_r - 32'd1;
               end
            end
         end
         ST_DONE: begin
            req_done_nx = 1'b1;
            state_nx    = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!mc_dv) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_DRAIN;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // FSM, counters and registered stream/pulse outputs
   always_ff @(posedge rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r        <= ST_IDLE;
         idx_r          <= 5'd0;
         len_r          <= 32'd0;
         armed_r        <= 1'b0;
         hdr_valid_r    <= 1'b0;
         key_dv_r       <= 1'b0;
         key_data_r     <= 8'd0;
         key_hash_vld_r <= 1'b0;
         val_dv_r       <= 1'b0;
         val_data_r     <= 8'd0;
         req_done_r     <= 1'b0;
         err_vld_r      <= 1'b0;
         err_code_r     <= ERR_NONE;
      end else begin
         state_r        <= state_nx;
         idx_r          <= idx_nx;
         len_r          <= len_nx;
         armed_r        <= armed_r | ~mc_dv;
         hdr_valid_r    <= hdr_valid_nx;
         key_dv_r       <= key_dv_nx;
         key_data_r     <= key_dv_nx ? mc_data : key_data_r;
         key_hash_vld_r <= key_hash_vld_nx;
         val_dv_r       <= val_dv_nx;
         val_data_r     <= val_dv_nx ? mc_data : val_data_r;
         req_done_r     <= req_done_nx;
         err_vld_r      <= err_vld_nx;
         err_code_r     <= err_code_nx;
      end
   end

   // Header field capture by byte index; CAS and reserved bytes fall through
   always_ff @(posedge rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hdr_magic_r    <= 8'd0;
         hdr_opcode_r   <= 8'd0;
         hdr_key_len_r  <= 16'd0;
         hdr_ext_len_r  <= 8'd0;
         hdr_body_len_r <= 32'd0;
         hdr_opaque_r   <= 32'd0;
      end else if (hdr_cap_s) begin
         case (idx_r)
            5'd0:    hdr_magic_r           <= mc_data;
            5'd1:    hdr_opcode_r          <= mc_data;
            5'd2:    hdr_key_len_r[15:8]   <= mc_data;
            5'd3:    hdr_key_len_r[7:0]    <= mc_data;
            5'd4:    hdr_ext_len_r         <= mc_data;
            5'd8:    hdr_body_len_r[31:24] <= mc_data;
            5'd9:    hdr_body_len_r[23:16] <= mc_data;
            5'd10:   hdr_body_len_r[15:8]  <= mc_data;
            5'd11:   hdr_body_len_r[7:0]   <= mc_data;
            5'd12:   hdr_opaque_r[31:24]   <= mc_data;
            5'd13:   hdr_opaque_r[23:16]   <= mc_data;
            5'd14:   hdr_opaque_r[15:8]    <= mc_data;
            5'd15:   hdr_opaque_r[7:0]     <= mc_data;
            default: hdr_magic_r           <= hdr_magic_r;
         endcase
      end
   end

   kvs_key_hash #(.HASH_W(HASH_W)) u_key_hash (
      .rx_clk  (rx_clk),
      .sys_rst (sys_rst),
      .clr     (hash_clr_s),
      .en      (hash_en_s),
      .data    (mc_data),
      .hash    (key_hash)
   );

   assign hdr_valid    = hdr_valid_r;
   assign hdr_magic    = hdr_magic_r;
   assign hdr_opcode   = hdr_opcode_r;
   assign hdr_key_len  = hdr_key_len_r;
   assign hdr_ext_len  = hdr_ext_len_r;
   assign hdr_body_len = hdr_body_len_r;
   assign hdr_opaque   = hdr_opaque_r;
   assign key_dv       = key_dv_r;
   assign key_data     = key_data_r;
   assign key_hash_vld = key_hash_vld_r;
   assign val_dv       = val_dv_r;
   assign val_data     = val_data_r;
   assign req_done     = req_done_r;
   assign err_vld      = err_vld_r;
   assign err_code     = err_code_r;

endmodule
